// File: rtl/mod_n_digit_counter_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock datapath digit counters.
//   cnt_state_t : RUN / SET mode of a digit counter
//   min_w       : unsigned clamp helper (smaller of two values)
//   SEC_U..HR_T : modulus of each digit position of an HH:MM:SS clock
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [0:0] {
        CNT_RUN = 1'b0,
        CNT_SET = 1'b1
    } cnt_state_t;

    localparam int unsigned SEC_U = 32'd10;
    localparam int unsigned SEC_T = 32'd6;
    localparam int unsigned MIN_U = 32'd10;
    localparam int unsigned MIN_T = 32'd6;
    localparam int unsigned HR_U  = 32'd10;
    localparam int unsigned HR_T  = 32'd3;

    // Smaller of two unsigned values; callers cast back to their own width.
    function automatic int unsigned min_w(input int unsigned a, input int unsigned b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/mod_n_digit_counter_if.sv
// -----------------------------------------------------------------------------
// mod_n_digit_counter_if
// Control and status bundle of one digit counter stage.
//   master : drives tick, set_time, set_up, set_dn, limit_en, limit, load,
//            load_val; observes count, carry_out, at_max
//   slave  : the counter itself (opposite directions)
// -----------------------------------------------------------------------------
interface mod_n_digit_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             tick;
    logic             set_time;
    logic             set_up;
    logic             set_dn;
    logic             limit_en;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             carry_out;
    logic             at_max;

    modport master (
        output tick, set_time, set_up, set_dn, limit_en, limit, load, load_val,
        input  count, carry_out, at_max
    );

    modport slave (
        input  tick, set_time, set_up, set_dn, limit_en, limit, load, load_val,
        output count, carry_out, at_max
    );

endinterface

// File: rtl/mod_n_digit_counter_edge_pulse.sv
// -----------------------------------------------------------------------------
// edge_pulse
// Rising-edge detector: pulse is high for the cycle in which level is 1 and
// was 0 at the previous clkmain edge. A level held high yields one pulse.
//   clkmain : main clock, rising edge
//   clear_n : asynchronous active-low reset (previous value cleared to 0)
//   level   : already synchronised/debounced input level
//   pulse   : one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module edge_pulse (
    input  logic clkmain,
    input  logic clear_n,
    input  logic level,
    output logic pulse
);

    logic prev_r;

    // Remember the level sampled at the previous edge.
    always_ff @(posedge clkmain or negedge clear_n) begin
        if (!clear_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    assign pulse = level & ~prev_r;

endmodule

// File: rtl/mod_n_digit_counter.sv
// -----------------------------------------------------------------------------
// mod_n_digit_counter
// One digit of the clock datapath: counts 0..T on carry-in ticks, emits a
// registered carry pulse on wrap, and can be stepped up/down by buttons in
// SET mode without propagating carry. T is MODULUS-1, or a smaller runtime
// limit when limit_en is set.
//   clkmain           : main clock, rising edge
//   clear_n           : asynchronous active-low reset
//   bus.tick          : carry-in from the lower stage
//   bus.set_time      : 1 = SET mode, 0 = RUN mode
//   bus.set_up/set_dn : button levels, rising edge steps in SET mode
//   bus.limit_en/limit: runtime terminal value override
//   bus.load/load_val : synchronous load, clamped to T
//   bus.count         : current digit (registered)
//   bus.carry_out     : registered one-cycle wrap pulse
//   bus.at_max        : count >= T (combinational)
// -----------------------------------------------------------------------------
module mod_n_digit_counter
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic                  clkmain,
    input  logic                  clear_n,
    mod_n_digit_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] T_STATIC = WIDTH'(MODULUS - 32'd1);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(32'd0);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(32'd1);

    cnt_state_t       state_r;
    cnt_state_t       state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             carry_r;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] load_clamp_s;
    logic [WIDTH-1:0] step_s;
    logic             up_p_s;
    logic             dn_p_s;

    edge_pulse u_up_edge (
        .clkmain (clkmain),
        .clear_n (clear_n),
        .level   (bus.set_up),
        .pulse   (up_p_s)
    );

    edge_pulse u_dn_edge (
        .clkmain (clkmain),
        .clear_n (clear_n),
        .level   (bus.set_dn),
        .pulse   (dn_p_s)
    );

    // Terminal value and clamped load value, recomputed every cycle.
    always_comb begin
        t_s          = T_STATIC;
        load_clamp_s = ZERO_W;
        if (bus.limit_en) begin
            t_s = WIDTH'(min_w(32'(bus.limit), 32'(T_STATIC)));
        end else begin
            t_s = T_STATIC;
        end
        load_clamp_s = WIDTH'(min_w(32'(bus.load_val), 32'(t_s)));
    end

    // Next-state, next-count and next-carry decision.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        carry_nxt_s = 1'b0;
        step_s      = count_r;

        if (bus.set_time) begin
            state_nxt_s = CNT_SET;
        end else begin
            state_nxt_s = CNT_RUN;
        end

        if (bus.load) begin
            count_nxt_s = load_clamp_s;
        end else begin
            case (state_r)
                CNT_RUN: begin
                    if (bus.tick) begin
                        // >= rather than == so an out-of-range count wraps too.
                        if (count_r >= t_s) begin
                            count_nxt_s = ZERO_W;
                            carry_nxt_s = 1'b1;
                        end else begin
                            count_nxt_s = count_r + ONE_W;
                        end
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
                CNT_SET: begin
                    if (up_p_s && !dn_p_s) begin
                        if (count_r >= t_s) begin
                            step_s = ZERO_W;
                        end else begin
                            step_s = count_r + ONE_W;
                        end
                    end else if (dn_p_s && !up_p_s) begin
                        if (count_r == ZERO_W) begin
                            step_s = t_s;
                        end else if (count_r > t_s) begin
                            step_s = t_s;
                        end else begin
                            step_s = count_r - ONE_W;
                        end
                    end else begin
                        step_s = count_r;
                    end
                    // Leaving SET: pull a count stranded above T back to T.
                    if (!bus.set_time && (step_s > t_s)) begin
                        count_nxt_s = t_s;
                    end else begin
                        count_nxt_s = step_s;
                    end
                end
                default: begin
                    state_nxt_s = CNT_RUN;
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // State, count and carry registers.
    always_ff @(posedge clkmain or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= CNT_RUN;
            count_r <= ZERO_W;
            carry_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

    assign bus.count     = count_r;
    assign bus.carry_out = carry_r;
    assign bus.at_max    = (count_r >= t_s);

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_digit_counter
// Directed bench for a MODULUS=10, WIDTH=4 digit. The stimulus process sets
// inputs on the falling edge and queues the hand-computed values expected
// after the following rising edge; the monitor pops and compares them just
// after that rising edge (or immediately, for asynchronous reset checks).
// -----------------------------------------------------------------------------
module tb_mod_n_digit_counter;

    typedef struct {
        int unsigned due;
        logic [3:0]  cnt;
        logic        car;
        logic        mx;
        string       name;
    } exp_t;

    logic        clkmain;
    logic        clear_n;
    int unsigned cyc;
    int          n_vec;
    int          n_miss;
    exp_t        sb[$];
    event        chk_ev;

    mod_n_digit_counter_if #(.WIDTH(4)) bus ();

    mod_n_digit_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clkmain (clkmain),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial begin
        clkmain = 1'b0;
        forever #5 clkmain = ~clkmain;
    end

    always @(posedge clkmain) cyc <= cyc + 32'd1;

    // Monitor: compare every queued expectation that has come due.
    initial begin
        forever begin
            @(posedge clkmain or chk_ev);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (bus.count !== e.cnt || bus.carry_out !== e.car || bus.at_max !== e.mx) begin
                    n_miss++;
                    $display("FAIL %s: got count=%0d carry=%b at_max=%b, want count=%0d carry=%b at_max=%b",
                             e.name, bus.count, bus.carry_out, bus.at_max, e.cnt, e.car, e.mx);
                end
            end
        end
    end

    // Expect these values after the next rising edge, then move to the next falling edge.
    task automatic step(input string nm, input logic [3:0] c, input logic cr, input logic m);
        exp_t e;
        e.due = cyc + 32'd1; e.cnt = c; e.car = cr; e.mx = m; e.name = nm;
        sb.push_back(e);
        @(negedge clkmain);
    endtask

    // Expect these values right now (between edges).
    task automatic check_now(input string nm, input logic [3:0] c, input logic cr, input logic m);
        exp_t e;
        e.due = cyc; e.cnt = c; e.car = cr; e.mx = m; e.name = nm;
        sb.push_back(e);
        -> chk_ev;
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; n_vec = 0; n_miss = 0;
        clear_n = 1'b0;
        bus.tick = 1'b0; bus.set_time = 1'b0; bus.set_up = 1'b0; bus.set_dn = 1'b0;
        bus.limit_en = 1'b0; bus.limit = 4'd0; bus.load = 1'b0; bus.load_val = 4'd0;

        // Reset state
        @(negedge clkmain);
        #2;
        check_now("reset", 4'd0, 1'b0, 1'b0);
        @(negedge clkmain);
        clear_n = 1'b1;

        // Free-running count 0..9,0 with one carry
        bus.tick = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("run%0d", i), 4'(i), 1'b0, (i == 9));
        end
        step("run_wrap", 4'd0, 1'b1, 1'b0);
        step("run_after_wrap", 4'd1, 1'b0, 1'b0);
        bus.tick = 1'b0;
        step("run_hold", 4'd1, 1'b0, 1'b0);

        // Runtime limit 3
        bus.load = 1'b1; bus.load_val = 4'd0;
        step("load0", 4'd0, 1'b0, 1'b0);
        bus.load = 1'b0; bus.limit_en = 1'b1; bus.limit = 4'd3; bus.tick = 1'b1;
        step("lim1", 4'd1, 1'b0, 1'b0);
        step("lim2", 4'd2, 1'b0, 1'b0);
        step("lim3", 4'd3, 1'b0, 1'b1);
        step("lim_wrap", 4'd0, 1'b1, 1'b0);
        step("lim_again1", 4'd1, 1'b0, 1'b0);
        bus.limit_en = 1'b0; bus.tick = 1'b0; bus.load = 1'b1; bus.load_val = 4'd7;
        step("load7", 4'd7, 1'b0, 1'b0);
        bus.load = 1'b0; bus.limit_en = 1'b1; bus.tick = 1'b1;
        step("over_limit_wrap", 4'd0, 1'b1, 1'b0);
        bus.limit_en = 1'b0; bus.tick = 1'b0;

        // SET mode
        bus.set_time = 1'b1;
        step("enter_set", 4'd0, 1'b0, 1'b0);
        bus.set_dn = 1'b1;
        step("dn_from0", 4'd9, 1'b0, 1'b1);
        bus.set_dn = 1'b0;
        step("dn_release", 4'd9, 1'b0, 1'b1);
        bus.set_up = 1'b1;
        step("up_wrap", 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("up_held%0d", i), 4'd0, 1'b0, 1'b0);
        end
        bus.set_up = 1'b0;
        step("up_release", 4'd0, 1'b0, 1'b0);
        bus.set_up = 1'b1; bus.set_dn = 1'b1;
        step("both", 4'd0, 1'b0, 1'b0);
        bus.set_up = 1'b0; bus.set_dn = 1'b0;
        step("both_release", 4'd0, 1'b0, 1'b0);
        bus.set_up = 1'b1;
        step("up_inc", 4'd1, 1'b0, 1'b0);
        bus.set_up = 1'b0; bus.tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("set_tick%0d", i), 4'd1, 1'b0, 1'b0);
        end
        bus.tick = 1'b0; bus.set_dn = 1'b1;
        step("dn_dec", 4'd0, 1'b0, 1'b0);
        bus.set_dn = 1'b0;

        // Load above T clamps, in SET mode
        bus.load = 1'b1; bus.load_val = 4'd12;
        step("load12", 4'd9, 1'b0, 1'b1);
        bus.load_val = 4'd8;
        step("load8", 4'd8, 1'b0, 1'b0);
        bus.load = 1'b0;

        // Asynchronous reset mid-SET, then RUN after release
        #3;
        clear_n = 1'b0;
        check_now("async_reset", 4'd0, 1'b0, 1'b0);
        @(negedge clkmain);
        bus.set_time = 1'b0; clear_n = 1'b1; bus.tick = 1'b1;
        step("post_reset_tick", 4'd1, 1'b0, 1'b0);

        // Load beats tick, and suppresses carry at terminal
        bus.load = 1'b1; bus.load_val = 4'd5;
        step("load_tick5", 4'd5, 1'b0, 1'b0);
        bus.load_val = 4'd9;
        step("load_tick9", 4'd9, 1'b0, 1'b1);
        step("load_tick9_at_T", 4'd9, 1'b0, 1'b1);
        bus.load = 1'b0; bus.tick = 1'b0;

        // SET->RUN clamp with limit 3; tick on the transition edge is ignored
        bus.load = 1'b1; bus.load_val = 4'd7;
        step("clamp_load7", 4'd7, 1'b0, 1'b0);
        bus.load = 1'b0; bus.set_time = 1'b1;
        step("clamp_set", 4'd7, 1'b0, 1'b0);
        bus.limit_en = 1'b1; bus.limit = 4'd3;
        step("clamp_limit", 4'd7, 1'b0, 1'b1);
        bus.set_time = 1'b0; bus.tick = 1'b1;
        step("clamp_exit", 4'd3, 1'b0, 1'b1);
        step("clamp_wrap", 4'd0, 1'b1, 1'b0);
        step("clamp_next", 4'd1, 1'b0, 1'b0);
        bus.tick = 1'b0;

        @(negedge clkmain);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mod_n_digit_counter.md
# mod_n_digit_counter

Parametrised modulo-N digit counter for the clock datapath, generalising the fixed mod-3 tens-of-hours stage to any digit position (seconds/minutes units and tens, hours units and tens). It advances on a carry-in tick, emits a registered carry-out pulse for cascading, and supports a runtime terminal-value override (e.g. hours-units 0-3 when hours-tens is 2). In time-setting mode it steps up or down on button edges, without propagating carry.

## Interface
- WIDTH, 4, count register width; must satisfy 2^WIDTH >= MODULUS
- MODULUS, 10, static modulus; the static terminal value is MODULUS-1
- clkmain  in  1  main clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- tick  in  1  carry-in; single-cycle pulse from the lower stage, or 1 for the least-significant stage
- set_time  in  1  level; 1 = SET mode, 0 = RUN mode
- set_up  in  1  synchronous button level; its rising edge steps the count up in SET mode
- set_dn  in  1  synchronous button level; its rising edge steps the count down in SET mode
- limit_en  in  1  when 1, use limit as the terminal value
- limit  in  WIDTH  runtime terminal value
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current digit
- carry_out  out  1  registered one-cycle wrap pulse
- at_max  out  1  combinational: count >= T

## Operation
- Terminal value T = limit_en ? min(limit, MODULUS-1) : MODULUS-1, recomputed every cycle.
- States: RUN and SET. Transitions are RUN->SET when set_time=1 and SET->RUN when set_time=0, both evaluated at a clock edge.
- Edge detection: registered previous values of set_up and set_dn. up_p = set_up & ~prev_up; dn_p likewise.
- Per-edge priority: load, then state action.
  - load=1: count <= min(load_val, T); carry_out <= 0. Valid in either state.
  - RUN with tick=1:
    - If count >= T: count <= 0 and carry_out <= 1.
    - Otherwise: count <= count+1 and carry_out <= 0.
  - RUN with tick=0: count holds; carry_out <= 0.
  - SET state: tick is ignored and carry_out <= 0 always.
    - up_p only: count wraps from >= T to 0, otherwise increments.
    - dn_p only: count wraps from 0 to T; if count > T it goes to T; otherwise it decrements.
    - up_p and dn_p together, or neither: count holds.
- Out-of-range count (count > T, after limit drops):
  - No change until the next RUN tick, which wraps to 0 with carry.
  - On the SET->RUN transition edge, count <= T if count > T.
- Arithmetic is unsigned in WIDTH bits and never relies on natural overflow. Wrap happens only via the compare with T.

## Timing
- Reset (clear_n=0, asynchronous, any time including mid-SET or mid-carry):
  - Outputs: count=0, carry_out=0, at_max=(0>=T).
  - Internal: state=RUN, prev_up=prev_dn=0.
  - Release is synchronous to the next clkmain edge.
- count changes on the clkmain edge where tick, load or a button edge is sampled, so latency is 1 cycle.
- carry_out is high for exactly the cycle after the wrapping edge, concurrent with count=0.
- Cascading: each stage adds one cycle of carry latency. Two consecutive ticks at terminal produce two separate wraps.
- A button held high produces one step only. It must return low for at least 1 cycle before the next step.
- A set_time change takes effect at the next edge. A tick arriving on the SET->RUN edge is ignored, because the state is still SET when it is sampled.
- Debouncing and synchronisation of set_up and set_dn happen upstream, not in this block.

## Structure
- Shared package clock_pkg:
  - state enum cnt_state_t {CNT_RUN, CNT_SET}
  - clamp function min_w(a,b)
  - digit modulus constants SEC_U=10, SEC_T=6, MIN_U=10, MIN_T=6, HR_U=10, HR_T=3
- Sub-module edge_pulse (parameter-free, clkmain/clear_n): rising-edge detector producing a one-cycle pulse. It is instantiated twice, for set_up and set_dn.
- The top level holds the state register, count register, carry register and the terminal-value mux.

## Test plan
- Reset and count: MODULUS=10, tick=1 continuously. Expect count 0..9,0. carry_out is high only in the cycle with count=0 after 9, i.e. once every 10 cycles.
- Runtime limit: MODULUS=10, limit_en=1, limit=3, tick each cycle. Expect 0,1,2,3,0 with carry. With count=7, set limit=3 then tick: expect count=0 and carry_out=1.
- SET mode: set_time=1, count=0.
  - set_dn edge: expect count=9, carry_out=0.
  - set_up held 5 cycles: expect exactly one step.
  - set_up and set_dn rising together: expect no change.
  - tick pulses during SET: expect no change.
- Load: load=1 with load_val=12 and T=9 gives count=9. load together with tick gives the loaded value, with no carry.
- Asynchronous reset mid-operation:
  - Assert clear_n=0 between edges while count=8 in SET: expect count=0 and carry_out=0 immediately.
  - After release, the first tick gives count=1 and state is RUN.
- SET->RUN clamp: limit_en=1, limit=3, SET mode with count=7 from load in RUN. Drop set_time: expect count=3 on the transition edge, and the next tick gives 0 with carry.
